lsu_dmem_responder: RTL



---
 rtl/rv32i_pkg.sv | 14 +
 rtl/lsu_dmem_rsp_fifo.sv | 66 ++++++
 rtl/lsu_dmem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: data-memory strobe width and the response record
// carried through the LSU data-memory pipeline and response FIFO.
package rv32i_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned DMEM_STRB_WIDTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic            we;
        logic            err;
    } dmem_rsp_t;

endpackage

// File: rtl/lsu_dmem_rsp_fifo.sv
// Synchronous FIFO of dmem_rsp_t records; output reads as all-zero while empty.
module lsu_dmem_rsp_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  dmem_rsp_t data_i,
    input  logic      pop_i,
    output dmem_rsp_t data_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    dmem_rsp_t       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push_ok, pop_ok;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/lsu_dmem_responder.sv
// LSU data-memory responder: word RAM, fixed-latency response pipeline, credit-limited
// in-order responses. Define LSU_DMEM_ADDR_ERR_EN to flag out-of-range addresses.
module lsu_dmem_responder
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned RSP_DEPTH   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_we,
    input  logic [31:0]                i_req_addr,
    input  logic [31:0]                i_req_wdata,
    input  logic [DMEM_STRB_WIDTH-1:0] i_req_strb,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [31:0]                o_rsp_rdata,
    output logic                       o_rsp_we,
    output logic                       o_rsp_err
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   idx;
    logic            accept, pop, req_err, push;
    logic            fifo_empty, fifo_full;
    dmem_rsp_t       new_rsp, push_rsp, fifo_rsp;
    logic            unused_sig;

    assign idx         = i_req_addr[2 +: AW];
    assign o_req_ready = !i_rst && (cnt_q < CntW'(RSP_DEPTH));
    assign accept      = i_req_valid && o_req_ready;
    assign pop         = o_rsp_valid && i_rsp_ready;

`ifdef LSU_DMEM_ADDR_ERR_EN
    assign req_err = ({2'b00, i_req_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
    assign req_err = 1'b0;
`endif
    assign unused_sig = ^{i_req_addr[1:0], i_req_addr[31:2+AW], fifo_full};

    always_comb begin
        new_rsp       = '0;
        new_rsp.we    = i_req_we;
        new_rsp.err   = req_err;
        new_rsp.rdata = (i_req_we || req_err) ? '0 : mem_q[idx];
    end

    // Array is deliberately not reset; stores survive a mid-flight reset.
    always_ff @(posedge i_clk) begin
        if (accept && i_req_we && !req_err) begin
            for (int k = 0; k < int'(DMEM_STRB_WIDTH); k++) begin
                if (i_req_strb[k]) mem_q[idx][8*k +: 8] <= i_req_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        unique case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // The FIFO write is the last latency cycle, so LATENCY-1 register stages precede it.
    if (LATENCY == 1) begin : g_lat1
        assign push     = accept;
        assign push_rsp = new_rsp;
    end else begin : g_pipe
        logic      vld_q  [LATENCY-1];
        dmem_rsp_t data_q [LATENCY-1];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int s = 0; s < int'(LATENCY) - 1; s++) vld_q[s] <= 1'b0;
            end else begin
                vld_q[0] <= accept;
                for (int s = 1; s < int'(LATENCY) - 1; s++) vld_q[s] <= vld_q[s-1];
            end
        end

        always_ff @(posedge i_clk) begin
            data_q[0] <= new_rsp;
            for (int s = 1; s < int'(LATENCY) - 1; s++) data_q[s] <= data_q[s-1];
        end

        assign push     = vld_q[LATENCY-2];
        assign push_rsp = data_q[LATENCY-2];
    end

    lsu_dmem_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (push),
        .data_i  (push_rsp),
        .pop_i   (pop),
        .data_o  (fifo_rsp),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign o_rsp_valid = !fifo_empty;
    assign o_rsp_rdata = fifo_rsp.rdata;
    assign o_rsp_we    = fifo_rsp.we;
    assign o_rsp_err   = fifo_rsp.err;

endmodule
